// File: rtl/mult_radix.sv
// -----------------------------------------------------------------------------
// mult_radix: iterative radix-2^NB multiplier covering MUL / MULH / MULHSU /
// MULHU, with early termination and a one-entry result cache.
//
// Parameters
//   W      operand width (multiple of NB, >= 8)
//   NB     multiplier bits retired per RUN cycle (1, 2, 4 or 8)
//   CACHE  1 = reuse the last completed product, 0 = always recompute
//
// Ports
//   clk     rising-edge clock
//   resetb  asynchronous active-low reset
//   start   request strobe, accepted only in IDLE with abort low
//   op      00 MUL (low), 01 MULH (s x s), 10 MULHSU (s x u), 11 MULHU (u x u)
//   rs1     multiplicand
//   rs2     multiplier
//   abort   cancels an operation in RUN or DONE
//   busy    high in RUN and DONE
//   done    one-cycle pulse, out valid
//   out     registered result word
// -----------------------------------------------------------------------------
module mult_radix #(
  parameter int W     = 32,
  parameter int NB    = 4,
  parameter int CACHE = 1
) (
  input  logic         clk,
  input  logic         resetb,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] rs1,
  input  logic [W-1:0] rs2,
  input  logic         abort,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] out
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q,  state_d;
  logic [1:0]       op_q,     op_d;      // also the cached signedness class
  logic [2*W-1:0]   mcand_q,  mcand_d;
  logic [W-1:0]     mplier_q, mplier_d;
  logic [2*W-1:0]   acc_q,    acc_d;     // also the cached full product
  logic [W-1:0]     out_q,    out_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic             cvld_q,   cvld_d;
  logic [W-1:0]     crs1_q,   crs1_d;
  logic [W-1:0]     crs2_q,   crs2_d;

  // Per-cycle datapath for one radix-2^NB digit.
  logic [2*W-1:0] partial;
  logic [2*W-1:0] acc_run;
  logic [W-1:0]   mplier_nxt;
  logic [2*W-1:0] mcand_ext;
  logic           neg;
  logic           hit;

  function automatic logic [W-1:0] pick(input logic [2*W-1:0] p, input logic [1:0] o);
    return (o == 2'b00) ? p[W-1:0] : p[2*W-1:W];
  endfunction

  always_comb begin
    partial    = mcand_q * {{(2*W-NB){1'b0}}, mplier_q[NB-1:0]};
    acc_run    = acc_q + partial;
    mplier_nxt = mplier_q >> NB;

    mcand_ext  = (op == 2'b01 || op == 2'b10) ? {{W{rs1[W-1]}}, rs1} : {{W{1'b0}}, rs1};
    // MULH with a negative multiplier: negate both sides so the digit loop
    // only ever sees a non-negative multiplier. The multiplicand is negated
    // after extension so that -(-2^(W-1)) stays correct in 2W bits.
    neg        = (op == 2'b01) && rs2[W-1];

    // A low-word request reuses any cached product (low bits do not depend on
    // signedness); a high-word request must also match the signedness class.
    hit = (CACHE != 0) && cvld_q && (rs1 == crs1_q) && (rs2 == crs2_q) &&
          ((op == 2'b00) || (op == op_q));
  end

  // NOTE: every next-state value gets a default first, so no path through the
  // case below can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    out_d    = out_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cvld_d   = cvld_q;
    crs1_d   = crs1_q;
    crs2_d   = crs2_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          busy_d = 1'b1;
          if (hit) begin
            state_d = S_DONE;
            out_d   = pick(acc_q, op);
            done_d  = 1'b1;
          end else begin
            state_d  = S_RUN;
            op_d     = op;
            crs1_d   = rs1;
            crs2_d   = rs2;
            cvld_d   = 1'b0;
            acc_d    = '0;
            mcand_d  = neg ? -mcand_ext : mcand_ext;
            mplier_d = neg ? -rs2 : rs2;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          cvld_d  = 1'b0;
        end else begin
          acc_d    = acc_run;
          mplier_d = mplier_nxt;
          mcand_d  = mcand_q << NB;
          if (mplier_nxt == '0) begin
            state_d = S_DONE;
            out_d   = pick(acc_run, op_q);
            done_d  = 1'b1;
            cvld_d  = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (abort) cvld_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values of the previous cycle regardless of statement order.
  // NOTE: the cache entry is a handful of flops, not a memory array, so it is
  // reset along with everything else; only the valid bit truly matters.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      out_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cvld_q   <= 1'b0;
      crs1_q   <= '0;
      crs2_q   <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      out_q    <= out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cvld_q   <= cvld_d;
      crs1_q   <= crs1_d;
      crs2_q   <= crs2_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign out  = out_q;

endmodule

// File: doc/mult_radix.md
MULT_RADIX -- requirements
Module: mult_radix

Interface
REQ-001 The module SHALL have parameter W, default 32, meaning operand width in bits; legal values are multiples of NB, at least 8.
REQ-002 The module SHALL have parameter NB, default 4, meaning multiplier bits retired per cycle; legal values are 1, 2, 4, 8.
REQ-003 The module SHALL have parameter CACHE, default 1, meaning 1 enables result reuse and 0 disables it.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 resetb  input  1  asynchronous reset, active-low.
REQ-006 start  input  1  request strobe, sampled in IDLE only.
REQ-007 op  input  2  operation: 00 MUL (low word), 01 MULH (s×s), 10 MULHSU (rs1 signed × rs2 unsigned), 11 MULHU (u×u).
REQ-008 rs1  input  W  multiplicand.
REQ-009 rs2  input  W  multiplier.
REQ-010 abort  input  1  cancels an operation in progress.
REQ-011 busy  output  1  high in RUN and DONE states.
REQ-012 done  output  1  one-cycle pulse; out valid.
REQ-013 out  output  W  result word, registered.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE; start is accepted only in IDLE with abort low; start in any other state, or with abort high, SHALL be ignored.
REQ-015 On acceptance, the block SHALL latch op, rs1 and rs2, and clear a 2W-bit accumulator.
REQ-016 For signed multiplier operands (op=01) with rs2 negative, the block SHALL negate both operands (two's complement) so that the multiplier is non-negative.
REQ-017 The multiplicand SHALL be sign-extended to 2W bits when op is 01 or 10, and zero-extended otherwise.
REQ-018 Each RUN cycle SHALL add (multiplicand × low NB multiplier bits) to the accumulator, shift the multiplier right by NB, and shift the multiplicand left by NB; all arithmetic is modulo 2^(2W).
REQ-019 Early termination: the FSM SHALL leave RUN for DONE after the cycle in which the shifted multiplier becomes zero; the maximum stay is W/NB cycles.
REQ-020 A zero multiplier SHALL take one RUN cycle.
REQ-021 On entering DONE, the block SHALL register out as acc[W-1:0] when op=00 and acc[2W-1:W] otherwise; done SHALL be 1 for that single DONE cycle, and the next state SHALL be IDLE.
REQ-022 out SHALL hold its value until the next DONE.
REQ-023 Latency SHALL be measured from the start-accept edge to the edge where done is high:
  - 1 + (RUN cycles);
  - maximum W/NB + 1;
  - zero multiplier: 2.
REQ-024 Cache (CACHE=1): the block SHALL retain the full 2W-bit product, operands and signedness class of the last completed operation.
REQ-025 A cache hit SHALL go from IDLE directly to DONE with latency 1 and no RUN cycles.
REQ-026 A new op=00 request SHALL hit the cache when rs1 and rs2 are equal to the stored operands, regardless of signedness.
REQ-027 A high-word request (op≠00) SHALL hit the cache when rs1, rs2 and the signedness class are all equal to the stored values.
REQ-028 Abort in RUN or DONE SHALL return the FSM to IDLE on the next edge, with no done pulse, out unchanged and the cache invalidated.
REQ-029 Abort in IDLE SHALL have no effect.
REQ-030 With CACHE=0, every request SHALL go through RUN.

Reset
REQ-031 While resetb is low, the block SHALL hold state=IDLE, busy=0, done=0, out=0, accumulator=0 and cache invalid, asynchronously.
REQ-032 Reset asserted mid-RUN SHALL discard the operation; after release, the first start SHALL behave as a cache miss.

Verification
REQ-033 The bench SHALL cover: W=32, NB=4, op=00, rs1=7, rs2=6 -> out=42; one RUN cycle; done 2 cycles after start.
REQ-034 The bench SHALL cover: op=11, rs1=rs2=0xFFFFFFFF -> out=0xFFFFFFFE; done 9 cycles after start; then op=01 with the same operands (miss) -> out=0x00000000.
REQ-035 The bench SHALL cover: op=10, rs1=0xFFFFFFFE, rs2=3 -> out=0xFFFFFFFF; then op=00 with the same operands (hit) -> out=0xFFFFFFFA, done 1 cycle after start.
REQ-036 The bench SHALL cover: op=11, rs1=rs2=0x80000000 -> out=0x40000000; start pulsed while busy is ignored, with exactly one done observed.
REQ-037 The bench SHALL cover: op=11, rs1=rs2=0xFFFFFFFF, abort 3 cycles after start -> no done and out unchanged; then the same request -> done after 9 cycles (cache miss), out=0xFFFFFFFE.
REQ-038 The bench SHALL cover: resetb low for 1 cycle mid-RUN -> busy=0, done=0 and out=0 immediately; then a repeat of the prior operands -> full RUN latency.
